// File: rtl/sd_pkg.sv
// Shared state type and frame constants for the SD CMD-line engine.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    TX_RELEASE,
    WAIT_RSP,
    RX,
    CHECK
  } sd_cmd_state_t;

  localparam int         CMD_FRAME_BITS = 48;
  localparam int         RSP_SHORT_BITS = 48;
  localparam int         RSP_LONG_BITS  = 136;
  localparam logic [6:0] CRC7_POLY      = 7'h09;
  localparam logic [5:0] LONG_RSP_INDEX = 6'h3F;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one message bit per enabled cycle, MSB first.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic       w_feedback;

  assign w_feedback = i_bit ^ r_crc[6];

  always_ff @(posedge i_clk) begin
    if (i_clear)
      r_crc <= '0;
    else if (i_enable)
      r_crc <= {r_crc[5:0], 1'b0} ^ (w_feedback ? CRC7_POLY : 7'h00);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd.sv
// SD CMD-line engine: sends a 48-bit command with CRC7 and collects the response.
// Define SD_CMD_LONG_RESPONSE_EN to expose the 120-bit R2 payload on o_response_long.
module sd_cmd
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_sd_clk_rising,
  input  logic         i_sd_clk_falling,
  input  logic         i_start,
  input  logic [5:0]   i_index,
  input  logic [31:0]  i_argument,
  input  logic         i_long_response,
  input  logic         i_skip_response,
  output logic         o_busy,
  output logic         o_timeout,
  output logic         o_crc_error,
  output logic [5:0]   o_index,
  output logic [31:0]  o_response,
`ifdef SD_CMD_LONG_RESPONSE_EN
  output logic [119:0] o_response_long,
`endif
  output logic         o_sd_cmd_oe,
  output logic         o_sd_cmd,
  input  logic         i_sd_cmd
);

  localparam int             TO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]     TX_LAST       = 6'(CMD_FRAME_BITS - 1);
  localparam logic [5:0]     TX_CRC_POS    = 6'(CMD_FRAME_BITS - 8);
  localparam logic [7:0]     RX_LAST_SHORT = 8'(RSP_SHORT_BITS - 1);
  localparam logic [7:0]     RX_LAST_LONG  = 8'(RSP_LONG_BITS - 1);

  sd_cmd_state_t r_state, w_next;

  logic            r_long, r_skip;
  logic            r_busy, r_timeout, r_crc_error, r_oe, r_cmd;
  logic [5:0]      r_tx_cnt, r_index, r_rx_idx;
  logic [7:0]      r_rx_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [39:0]     r_tx_sr, r_rx_sr;
  logic [31:0]     r_response;
  logic [6:0]      w_tx_crc, w_rx_crc;
  logic            w_accept, w_tx_bit, w_tx_crc_en;
  logic            w_rx_shift, w_rx_body, w_rx_crc_en, w_rx_last;

  assign w_accept    = (r_state == IDLE) && i_start;
  assign w_tx_bit    = (r_tx_cnt == TX_CRC_POS) ? w_tx_crc[6] : r_tx_sr[39];
  assign w_tx_crc_en = (r_state == TX) && i_sd_clk_falling && (r_tx_cnt < TX_CRC_POS);

  // The start bit is taken in WAIT_RSP, every later bit in RX.
  assign w_rx_shift  = i_sd_clk_rising &&
                       ((r_state == RX) || ((r_state == WAIT_RSP) && !i_sd_cmd));
  assign w_rx_body   = r_long ? ((r_rx_cnt >= 8'd8) && (r_rx_cnt < 8'd128))
                              : (r_rx_cnt < 8'd40);
  assign w_rx_crc_en = w_rx_shift && w_rx_body;
  assign w_rx_last   = (r_state == RX) && i_sd_clk_rising &&
                       (r_rx_cnt == (r_long ? RX_LAST_LONG : RX_LAST_SHORT));

  sd_crc7 u_tx_crc (
    .i_clk    (i_clk),
    .i_clear  (w_accept),
    .i_enable (w_tx_crc_en),
    .i_bit    (w_tx_bit),
    .o_crc    (w_tx_crc)
  );

  sd_crc7 u_rx_crc (
    .i_clk    (i_clk),
    .i_clear  (r_state == TX_RELEASE),
    .i_enable (w_rx_crc_en),
    .i_bit    (i_sd_cmd),
    .o_crc    (w_rx_crc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       if (i_start) w_next = TX;
      TX:         if (i_sd_clk_falling && (r_tx_cnt == TX_LAST)) w_next = TX_RELEASE;
      TX_RELEASE: if (i_sd_clk_falling) w_next = r_skip ? IDLE : WAIT_RSP;
      WAIT_RSP: begin
        if (i_sd_clk_rising) begin
          if (!i_sd_cmd)                  w_next = RX;
          else if (r_to_cnt == TO_LAST)   w_next = IDLE;
        end
      end
      RX:         if (w_rx_last) w_next = CHECK;
      CHECK:      w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_crc_error <= 1'b0;
      r_oe        <= 1'b0;
      r_cmd       <= 1'b1;
      r_index     <= '0;
      r_response  <= '0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_busy <= (r_state != IDLE) || w_accept;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_timeout   <= 1'b0;
            r_crc_error <= 1'b0;
            r_tx_cnt    <= '0;
          end
        end
        TX: begin
          if (i_sd_clk_falling) begin
            r_oe  <= 1'b1;
            r_cmd <= w_tx_bit;
            if (r_tx_cnt != TX_LAST) r_tx_cnt <= r_tx_cnt + 6'd1;
          end
        end
        TX_RELEASE: begin
          if (i_sd_clk_falling) begin
            r_oe     <= 1'b0;
            r_cmd    <= 1'b1;
            r_to_cnt <= '0;
            r_rx_cnt <= '0;
          end
        end
        WAIT_RSP: begin
          if (i_sd_clk_rising && i_sd_cmd) begin
            if (r_to_cnt == TO_LAST) r_timeout <= 1'b1;
            else                     r_to_cnt  <= r_to_cnt + TO_W'(1);
          end
        end
        CHECK: begin
          r_crc_error <= (w_rx_crc != r_rx_sr[7:1]) || !r_rx_sr[0];
          r_index     <= r_long ? LONG_RSP_INDEX : r_rx_idx;
          r_response  <= r_rx_sr[39:8];
        end
        default: ;
      endcase
      if (w_rx_shift && (r_rx_cnt != RX_LAST_LONG)) r_rx_cnt <= r_rx_cnt + 8'd1;
    end
  end

  // After bit 40 of the command the shifter is reloaded with CRC and end bit.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_tx_sr <= {2'b01, i_index, i_argument};
      r_long  <= i_long_response;
      r_skip  <= i_skip_response;
    end else if ((r_state == TX) && i_sd_clk_falling) begin
      if (r_tx_cnt == TX_CRC_POS) r_tx_sr <= {w_tx_crc[5:0], 1'b1, 33'd0};
      else                        r_tx_sr <= {r_tx_sr[38:0], 1'b0};
    end
    if (w_rx_shift) begin
      r_rx_sr <= {r_rx_sr[38:0], i_sd_cmd};
      if (r_rx_cnt == 8'd8) r_rx_idx <= r_rx_sr[5:0];
    end
  end

`ifdef SD_CMD_LONG_RESPONSE_EN
  logic [119:0] r_long_sr, r_response_long;

  always_ff @(posedge i_clk) begin
    if (w_rx_shift && r_long && w_rx_body) r_long_sr <= {r_long_sr[118:0], i_sd_cmd};
    if ((r_state == CHECK) && r_long)      r_response_long <= r_long_sr;
  end

  assign o_response_long = r_response_long;
`endif

  assign o_busy      = r_busy;
  assign o_timeout   = r_timeout;
  assign o_crc_error = r_crc_error;
  assign o_index     = r_index;
  assign o_response  = r_response;
  assign o_sd_cmd_oe = r_oe;
  assign o_sd_cmd    = r_cmd;

endmodule

// File: doc/sd_cmd.md
Name: sd_cmd

Overview:
- SD CMD-line engine; the consumer of the command controls produced by the SD register block (index, argument, long/skip, start).
- Serialises a 48-bit command frame with CRC7 onto CMD, then waits for and deserialises a 48- or 136-bit response.
- Reports busy, timeout, CRC/framing error, and the received index and 32-bit response back to the register block.
- Clocked on the system clock; SD bit timing comes from rise/fall strobes issued by the SD clock generator.

Parameters:
- TIMEOUT_CYCLES, 64, number of SD clock rising edges to wait for a response start bit before flagging timeout.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_sd_clk_rising  in  1  one-cycle strobe; card-side rising edge, used for sampling CMD
- i_sd_clk_falling  in  1  one-cycle strobe; falling edge, used for launching CMD
- i_start  in  1  start a command; accepted only when idle
- i_index  in  6  command index
- i_argument  in  32  command argument
- i_long_response  in  1  expect 136-bit (R2) response
- i_skip_response  in  1  no response expected
- o_busy  out  1  command in progress
- o_timeout  out  1  sticky until next accepted start
- o_crc_error  out  1  sticky until next accepted start; CRC mismatch or end bit = 0
- o_index  out  6  received index field (6'h3F for long responses)
- o_response  out  32  short response: frame bits [39:8]; long response: frame bits [39:8]
- o_sd_cmd_oe  out  1  CMD output enable
- o_sd_cmd  out  1  CMD output data
- i_sd_cmd  in  1  CMD input, already synchronised

Behaviour:
- Clocking and reset: clock i_clk; reset i_reset, synchronous, active-high.
- Reset values: state IDLE; o_busy=0, o_timeout=0, o_crc_error=0, o_index=0, o_response=0, o_sd_cmd_oe=0, o_sd_cmd=1.
- Reset mid-operation aborts the command and releases CMD at the next clock edge.
- Strobes: i_sd_clk_rising and i_sd_clk_falling are mutually exclusive by contract.
- States: IDLE, TX, TX_RELEASE, WAIT_RSP, RX, CHECK.
- IDLE:
  - i_start latches index, argument, long and skip; clears o_timeout and o_crc_error.
  - o_busy=1 on the next cycle; go to TX.
  - i_start while busy is ignored.
- TX:
  - On each falling strobe, drive the next bit MSB-first with oe=1.
  - Frame: 0, 1, index[5:0], arg[31:0], crc7[6:0], 1.
  - CRC7 (x^7+x^3+1, init 0) runs over the first 40 bits.
  - 6-bit bit counter; after the end bit, go to TX_RELEASE.
- TX_RELEASE:
  - On the next falling strobe, oe=0 and o_sd_cmd=1.
  - If skip: go to IDLE, o_busy=0 the cycle after.
  - Else: clear the timeout counter, go to WAIT_RSP.
- WAIT_RSP:
  - On each rising strobe, sample i_sd_cmd.
  - Sample 0 = start bit: go to RX with bit count 1.
  - Otherwise increment the counter; on reaching TIMEOUT_CYCLES, o_timeout=1 and go to IDLE.
- RX:
  - Shift one sample per rising strobe until 48 bits (short) or 136 bits (long) are collected; 8-bit counter.
  - Short: CRC7 over frame bits [47:8].
  - Long: CRC7 over frame bits [127:8]; header bits [135:128] are excluded.
  - Keep the last 40 received bits in a shift register.
- CHECK (one cycle):
  - o_crc_error = (computed CRC != bits [7:1]) OR bit[0]==0.
  - Short: o_index = bits[45:40]. Long: o_index = 6'h3F.
  - o_response = bits[39:8]; go to IDLE.
- o_busy falls the cycle after the return to IDLE.
- Outputs o_index and o_response are held until the next response completes.
- Bit counters saturate at their terminal values; no wrap.

Optional Feature:
- Macro SD_CMD_LONG_RESPONSE_EN.
- Defined:
  - Adds port o_response_long (out, 120) = frame bits [127:8] of the last R2 response.
  - Backed by a 120-bit shift register.
  - Unchanged on short responses.
- Undefined:
  - Port and register absent; long responses update only o_response, o_index and the flags.

Decomposition:
- Package sd_pkg holds:
  - state enum;
  - constants CMD_FRAME_BITS=48, RSP_SHORT_BITS=48, RSP_LONG_BITS=136;
  - CRC7_POLY=7'h09;
  - long-response index constant 6'h3F.
- Sub-module sd_crc7: serial CRC7 with i_clear, i_enable and i_bit inputs, o_crc[6:0] output.
  - Two instances: TX and RX.

Test Plan:
- CMD0, arg 0, skip=1 → CMD carries 0x400000000095 MSB-first, oe released after the end bit, o_busy clears, flags 0.
- CMD8, arg 0x000001AA → TX frame 0x48000001AA87. Bench model returns R7 0x08000001AA + correct CRC → o_index=8, o_response=0x000001AA, o_crc_error=0.
- Same exchange with one CRC bit flipped, and separately with end bit=0 → o_crc_error=1 for each case, o_timeout=0.
- CMD55, no card reply, CMD held high → o_timeout=1 exactly after 64 rising strobes post-release, o_busy=0 next cycle.
- CMD2, long response with a 136-bit model reply → o_index=6'h3F, o_response = frame[39:8], o_crc_error=0; with SD_CMD_LONG_RESPONSE_EN, o_response_long = frame[127:8].
- Reset asserted mid-TX (bit 20) → oe=0 and o_busy=0 next cycle. i_start pulsed while busy → ignored, frame unaltered.
